// File: rtl/port_capture_buffer.sv
// Per-port circular capture queues drained by a host over an Avalon-MM slave.
// Reads have a fixed two-cycle latency; control writes flush channels or clear overflow accounting.
module port_capture_buffer #(
    parameter int          NUM_PORTS  = 3,
    parameter int          DATA_W     = 32,
    parameter int          DEPTH      = 4096,
    parameter logic [31:0] EMPTY_CODE = 32'h000000FF,
    parameter logic [31:0] UNMAP_CODE = 32'h000000FC
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_PORTS-1:0]        wr_en,
    input  logic [NUM_PORTS*DATA_W-1:0] wr_data,
    input  logic                        chipselect,
    input  logic                        read,
    input  logic                        write,
    input  logic [5:0]                  address,
    input  logic [31:0]                 writedata,
    output logic [31:0]                 readdata,
    output logic                        readdatavalid
);
    localparam int ADDR_W = $clog2(DEPTH);
    localparam int CNT_W  = ADDR_W + 1;
    localparam int CH_W   = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    logic              w_rd_acc;
    logic              w_wr_ctl;
    logic              w_ch_ok;
    logic [CH_W-1:0]   w_ch;
    logic [CNT_W-1:0]  w_count  [NUM_PORTS];
    logic [31:0]       w_status [NUM_PORTS];
    logic [DATA_W-1:0] w_ram_q  [NUM_PORTS];
    logic              w_unused;

    // A read in the same cycle as a write wins; the write is dropped entirely.
    assign w_rd_acc = chipselect && read;
    assign w_wr_ctl = chipselect && write && !read && (address == 6'h30);
    assign w_ch_ok  = 32'(address[3:0]) < NUM_PORTS;
    assign w_ch     = w_ch_ok ? address[CH_W-1:0] : '0;
    assign w_unused = ^{writedata, address};

    for (genvar g = 0; g < NUM_PORTS; g++) begin : g_ch
        logic [DATA_W-1:0] r_mem [DEPTH];
        logic [DATA_W-1:0] r_ram_q;
        logic [ADDR_W-1:0] r_wr_ptr;
        logic [ADDR_W-1:0] r_rd_ptr;
        logic [CNT_W-1:0]  r_count;
        logic              r_ovf;
        logic [15:0]       r_drop;
        logic w_pop, w_cap, w_flush, w_clr, w_empty, w_full, w_pop_ok, w_cap_ok;

        assign w_pop    = w_rd_acc && (address[5:4] == 2'b00) && w_ch_ok && (address[3:0] == 4'(g));
        assign w_cap    = wr_en[g];
        assign w_flush  = w_wr_ctl && writedata[g];
        assign w_clr    = w_wr_ctl && writedata[16+g];
        assign w_empty  = (r_count == '0);
        assign w_full   = (r_count == CNT_W'(DEPTH));
        // Decisions use the pre-cycle count, so a full queue drops even while popping.
        assign w_pop_ok = w_pop && !w_empty;
        assign w_cap_ok = w_cap && !w_full;

        always_ff @(posedge clk) begin
            if (reset) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_count  <= '0;
                r_ovf    <= 1'b0;
                r_drop   <= '0;
            end else begin
                if (w_flush) begin
                    r_wr_ptr <= '0;
                    r_rd_ptr <= '0;
                    r_count  <= '0;
                end else begin
                    if (w_cap_ok) r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
                    if (w_pop_ok) r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
                    r_count <= r_count + CNT_W'(w_cap_ok) - CNT_W'(w_pop_ok);
                end
                if (w_clr) begin
                    r_ovf  <= 1'b0;
                    r_drop <= '0;
                end else if (w_cap && w_full && !w_flush) begin
                    r_ovf <= 1'b1;
                    if (r_drop != 16'hFFFF) r_drop <= r_drop + 16'd1;
                end
            end
        end

        always_ff @(posedge clk) begin
            if (w_cap_ok && !w_flush && !reset) r_mem[r_wr_ptr] <= wr_data[g*DATA_W +: DATA_W];
            r_ram_q <= r_mem[r_rd_ptr];
        end

        assign w_count[g]  = r_count;
        assign w_status[g] = {r_drop, 13'b0, r_ovf, w_full, w_empty};
        assign w_ram_q[g]  = r_ram_q;
    end

    logic              w_s1_use_ram;
    logic [31:0]       w_s1_word;
    logic              r_s1_valid;
    logic              r_s1_use_ram;
    logic [CH_W-1:0]   r_s1_ch;
    logic [31:0]       r_s1_word;

    always_comb begin
        w_s1_use_ram = 1'b0;
        w_s1_word    = UNMAP_CODE;
        case (address[5:4])
            2'b00: begin
                if (w_ch_ok) begin
                    if (w_count[w_ch] == '0) w_s1_word = EMPTY_CODE;
                    else                     w_s1_use_ram = 1'b1;
                end
            end
            2'b01:   if (w_ch_ok) w_s1_word = 32'(w_count[w_ch]);
            2'b10:   if (w_ch_ok) w_s1_word = w_status[w_ch];
            default: if (address[3:0] == 4'd0) w_s1_word = 32'd0;
        endcase
    end

    // Stage 1 captures the decoded reply at T while the RAM word registers; stage 2 drives the bus.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1_valid    <= 1'b0;
            r_s1_use_ram  <= 1'b0;
            r_s1_ch       <= '0;
            r_s1_word     <= '0;
            readdata      <= '0;
            readdatavalid <= 1'b0;
        end else begin
            r_s1_valid    <= w_rd_acc;
            r_s1_use_ram  <= w_s1_use_ram;
            r_s1_ch       <= w_ch;
            r_s1_word     <= w_s1_word;
            readdatavalid <= r_s1_valid;
            if (r_s1_valid) readdata <= r_s1_use_ram ? 32'(w_ram_q[r_s1_ch]) : r_s1_word;
        end
    end
endmodule

// File: tb/tb_port_capture_buffer.sv
// Randomised and directed bench for port_capture_buffer with a queue-based reference model
// and a decoupled monitor that checks every readdatavalid beat against the expected queue.
module tb_port_capture_buffer;
    localparam int NP    = 3;
    localparam int DW    = 32;
    localparam int DEPTH = 8;

    logic              clk = 1'b0;
    logic              reset;
    logic [NP-1:0]     wr_en;
    logic [NP*DW-1:0]  wr_data;
    logic              chipselect, read, write;
    logic [5:0]        address;
    logic [31:0]       writedata;
    logic [31:0]       readdata;
    logic              readdatavalid;

    port_capture_buffer #(.NUM_PORTS(NP), .DATA_W(DW), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data),
        .chipselect(chipselect), .read(read), .write(write), .address(address),
        .writedata(writedata), .readdata(readdata), .readdatavalid(readdatavalid)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [31:0] mq [NP][$];
    logic        m_ovf  [NP];
    logic [15:0] m_drop [NP];
    logic [31:0] exp_q [$];
    int          exp_cyc_q [$];
    int          errors = 0;
    int          checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int c = 0; c < NP; c++) begin
            mq[c].delete();
            m_ovf[c]  = 1'b0;
            m_drop[c] = 16'd0;
        end
    endtask

    // One bus cycle: predict the reply from the pre-cycle model, then apply the cycle to the model.
    task automatic step(input logic [NP-1:0] we, input logic [NP*DW-1:0] wd, input logic cs,
                        input logic rd, input logic wr, input logic [5:0] addr, input logic [31:0] wdat);
        logic [31:0] e;
        int ch, sz, pop_ch;
        logic racc, wacc;
        @(negedge clk);
        wr_en = we; wr_data = wd; chipselect = cs; read = rd; write = wr;
        address = addr; writedata = wdat;
        racc = cs && rd;
        wacc = cs && wr && !rd && (addr == 6'h30);
        pop_ch = -1;
        ch = int'(addr[3:0]);
        if (racc) begin
            e = 32'h000000FC;
            if (addr[5:4] == 2'b11) begin
                if (addr[3:0] == 4'd0) e = 32'd0;
            end else if (ch < NP) begin
                sz = mq[ch].size();
                if (addr[5:4] == 2'b00) begin
                    if (sz == 0) e = 32'h000000FF;
                    else begin e = mq[ch][0]; pop_ch = ch; end
                end else if (addr[5:4] == 2'b01) e = sz;
                else e = {m_drop[ch], 13'b0, m_ovf[ch], sz == DEPTH, sz == 0};
            end
            exp_q.push_back(e);
            exp_cyc_q.push_back(cyc);
        end
        for (int c = 0; c < NP; c++) begin
            if (wacc && wdat[c]) mq[c].delete();
            else begin
                sz = mq[c].size();
                if (pop_ch == c) void'(mq[c].pop_front());
                if (we[c]) begin
                    if (sz == DEPTH) begin
                        m_ovf[c] = 1'b1;
                        if (m_drop[c] != 16'hFFFF) m_drop[c] = m_drop[c] + 16'd1;
                    end else mq[c].push_back(wd[c*DW +: DW]);
                end
            end
            if (wacc && wdat[16+c]) begin
                m_ovf[c]  = 1'b0;
                m_drop[c] = 16'd0;
            end
        end
    endtask

    task automatic idle();
        step('0, '0, 1'b0, 1'b0, 1'b0, 6'h0, 32'h0);
    endtask

    task automatic rd(input logic [5:0] addr);
        step('0, '0, 1'b1, 1'b1, 1'b0, addr, 32'h0);
    endtask

    task automatic cap(input int ch, input logic [31:0] d);
        logic [NP*DW-1:0] wd;
        logic [NP-1:0] we;
        wd = '0; we = '0;
        wd[ch*DW +: DW] = d;
        we[ch] = 1'b1;
        step(we, wd, 1'b0, 1'b0, 1'b0, 6'h0, 32'h0);
    endtask

    task automatic ctl(input logic [31:0] d);
        step('0, '0, 1'b1, 1'b0, 1'b1, 6'h30, d);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        wr_en = '0; chipselect = 1'b0; read = 1'b0; write = 1'b0;
        exp_q.delete();
        exp_cyc_q.delete();
        model_clear();
        @(posedge clk);
        #1;
        check("rst_valid", {31'b0, readdatavalid}, 32'd0);
        check("rst_rdata", readdata, 32'd0);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Monitor: every valid beat must match the oldest prediction and arrive two cycles after issue.
    initial begin
        logic [31:0] e;
        int c;
        forever begin
            @(posedge clk);
            #1;
            if (readdatavalid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_valid: got readdata 0x%08h with no read pending", readdata);
                end else begin
                    e = exp_q.pop_front();
                    c = exp_cyc_q.pop_front();
                    check("readdata", readdata, e);
                    check("latency", cyc - c, 32'd2);
                end
            end
        end
    end

    initial begin
        logic [NP*DW-1:0] wd;
        logic [NP-1:0] we;
        logic [5:0] a;
        logic [31:0] wdat;
        int r;
        reset = 1'b1;
        wr_en = '0; wr_data = '0; chipselect = 1'b0; read = 1'b0; write = 1'b0;
        address = '0; writedata = '0;
        model_clear();
        repeat (3) @(negedge clk);
        check("rst_valid_init", {31'b0, readdatavalid}, 32'd0);
        reset = 1'b0;

        rd(6'h00); rd(6'h20); rd(6'h13); rd(6'h30); rd(6'h31);

        cap(1, 32'hA); cap(1, 32'hB); cap(1, 32'hC);
        repeat (4) rd(6'h01);
        rd(6'h11);

        for (int i = 1; i <= 10; i++) cap(2, i);
        rd(6'h12); rd(6'h22);
        repeat (8) rd(6'h02);
        rd(6'h22);

        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 6; i++) cap(0, 32'h100 * (k + 1) + i);
            repeat (6) rd(6'h00);
        end
        rd(6'h10);

        for (int i = 0; i < 5; i++) cap(0, 32'h50 + i);
        step(3'b001, {64'h0, 32'hDEAD}, 1'b1, 1'b0, 1'b1, 6'h30, 32'h1);
        rd(6'h10); rd(6'h20); rd(6'h00);

        for (int i = 0; i < 8; i++) cap(0, 32'h600 + i);
        step(3'b001, {64'h0, 32'hBEEF}, 1'b1, 1'b1, 1'b0, 6'h00, 32'h0);
        rd(6'h20); rd(6'h10);
        ctl(32'h10000);
        rd(6'h20);
        ctl(32'h7);
        idle(); idle();

        for (int n = 0; n < 1500; n++) begin
            we = 3'($urandom_range(0, 7));
            for (int c = 0; c < NP; c++) wd[c*DW +: DW] = $urandom;
            r = $urandom_range(0, 99);
            if ($urandom_range(0, 1) == 0) a = 6'($urandom_range(0, 63));
            else a = {2'($urandom_range(0, 3)), 4'($urandom_range(0, 3))};
            wdat = '0;
            if (r < 40) step(we, wd, 1'b1, 1'b1, 1'b0, a, 32'h0);
            else if (r < 42) begin
                wdat[NP-1:0]     = NP'($urandom_range(0, 7));
                wdat[16+NP-1:16] = NP'($urandom_range(0, 7));
                step(we, wd, 1'b1, 1'b0, 1'b1, 6'h30, wdat);
            end
            else if (r < 45) step(we, wd, 1'b1, 1'b1, 1'b1, 6'h30, 32'h7);
            else if (r < 48) step(we, wd, 1'b0, 1'b1, 1'b0, a, 32'h0);
            else if (r < 50) step(we, wd, 1'b1, 1'b0, 1'b1, a, $urandom);
            else step(we & 3'($urandom_range(0, 7)), wd, 1'b0, 1'b0, 1'b0, 6'h0, 32'h0);
        end

        rd(6'h00); rd(6'h01); rd(6'h02);
        do_reset();
        rd(6'h10); rd(6'h11); rd(6'h12); rd(6'h20);
        repeat (4) idle();
        check("drain", exp_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
